hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
//  Next-gen hazard unit for the 5-stage RISC-V pipeline. Adds a scoreboard for one
//  non-pipelined multi-cycle unit (MC, e.g. mul/div) alongside M/W forwarding and
//  load-use stalls. Generates stall/flush/forward controls for IF/ID/EX and counts
//  stall cycles. Sits beside the datapath; all inputs come from pipeline registers.
// PARAMETERS
//  REG_COUNT  32  architectural registers (x0 hardwired zero)
//  ADDR_W     5   register index width, clog2(REG_COUNT)
//  MC_LAT     4   MC latency: cycles from issue in EX to mcDone pulse (>=2)
//  CNT_W      32  width of stall-cycle counter
// PORTS
//  clk         in   1       clock, rising edge
//  rst         in   1       synchronous, active-high reset
//  rs1D/rs2D   in   ADDR_W  source regs in decode
//  rdD         in   ADDR_W  dest reg in decode
//  regWriteD   in   1       decode instr writes rdD
//  rs1E/rs2E   in   ADDR_W  source regs in execute
//  rdE         in   ADDR_W  dest reg in execute
//  resultSrcE  in   1       EX instr is a load
//  mcIssueE    in   1       EX instr targets MC unit
//  PCSrcE      in   1       taken branch/jump resolved in EX
//  rdM/rdW     in   ADDR_W  dest reg in memory / writeback
//  regWriteM   in   1       M instr writes rdM
//  regWriteW   in   1       W instr writes rdW
//  stallF      out  1       hold PC
//  stallD      out  1       hold IF/ID register
//  stallE      out  1       hold ID/EX register (structural MC stall)
//  flushD      out  1       clear IF/ID register
//  flushE      out  1       clear ID/EX register (insert bubble)
//  forwardAE   out  2       00 RF, 10 M, 01 W, 11 MC result
//  forwardBE   out  2       same encoding for rs2E
//  mcDone      out  1       one-cycle pulse: MC result valid this cycle
//  mcRd        out  ADDR_W  destination of completing MC op
//  stallCount  out  CNT_W   cycles with stallF=1, saturating
// BEHAVIOUR
//  Reset: busy[] all 0, MC idle, countdown 0, mcDone=0, mcRd=0, stallCount=0.
//  Comb outputs follow inputs with x0 rules applied; no X during reset.
//  x0 rule: index 0 never forwards, never marks busy, never causes any stall.
//  Forwarding (per operand, priority M > W > MC): rsE==rdM&&regWriteM->10;
//   else rsE==rdW&&regWriteW->01; else rsE==mcRd&&mcDone->11; else 00.
//  MC FSM IDLE/BUSY: IDLE & mcIssueE & !stallE & rdE!=0 -> BUSY, busy[rdE]=1,
//   cnt=MC_LAT-1, mcRd=rdE. BUSY: cnt-- each cycle; at cnt==0 mcDone=1 that cycle,
//   busy[mcRd] clears next edge, -> IDLE. mcIssueE with rdE==0 occupies unit too
//   (busy[] untouched). Back-to-back: issue accepted in the same cycle as mcDone.
//  Structural stall: mcIssueE & BUSY & !mcDone -> stallE=stallD=stallF=1.
//  Scoreboard stall: busy[rs1D]|busy[rs2D] (RAW) or regWriteD&busy[rdD] (WAW),
//   unless the match completes via mcDone this cycle -> stallF=stallD=1, flushE=1.
//  Load-use: resultSrcE & rdE!=0 & (rs1D==rdE | rs2D==rdE) -> stallF=stallD=1,
//   flushE=1.
//  Branch: PCSrcE -> flushD=1, flushE=1; clears scoreboard/load stalls that cycle
//   (wrong-path decode). MC op already in BUSY continues unaffected.
//  stallCount += 1 every cycle stallF=1; holds at 2^CNT_W-1.
//  Reset mid-op: MC aborts, no mcDone pulse, busy[] cleared next cycle.
// TESTING
//  T1 add x5 in M, rs1E=5, regWriteM=1, also rdW=5 -> forwardAE=10 (M wins).
//  T2 lw x3 in EX, rs2D=3 -> stallF=stallD=flushE=1 one cycle; rdE=0 -> no stall.
//  T3 MC issue rdE=7 (MC_LAT=4) -> busy[7] cycles 1-3, mcDone=1,mcRd=7 at cycle 4;
//     rs1D=7 stalls cycles 1-3, released cycle 4; rs1E=7 at cycle 4 -> forwardAE=11.
//  T4 second mcIssueE while BUSY cnt=2 -> stallE/D/F=1 two cycles, accepted on
//     mcDone cycle; stallCount incremented by 2.
//  T5 PCSrcE=1 with load-use condition present -> flushD=flushE=1, stallF=stallD=0.
//  T6 rst=1 while BUSY cnt=1 -> no mcDone, busy[]=0, stallCount=0; CNT_W=4 bench
//     with 20 stall cycles -> stallCount=15.

Source files
------------

// File: rtl/hazard_scoreboard_if.sv
// Control bundle between the 5-stage pipeline and its hazard/scoreboard unit.
// The pipeline side drives the register indices and qualifiers; the hazard unit returns stall/flush/forward controls.
interface hazard_scoreboard_if #(
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
) ();
    logic [ADDR_W-1:0] rs1D;
    logic [ADDR_W-1:0] rs2D;
    logic [ADDR_W-1:0] rdD;
    logic              regWriteD;
    logic [ADDR_W-1:0] rs1E;
    logic [ADDR_W-1:0] rs2E;
    logic [ADDR_W-1:0] rdE;
    logic              resultSrcE;
    logic              mcIssueE;
    logic              PCSrcE;
    logic [ADDR_W-1:0] rdM;
    logic [ADDR_W-1:0] rdW;
    logic              regWriteM;
    logic              regWriteW;
    logic              stallF;
    logic              stallD;
    logic              stallE;
    logic              flushD;
    logic              flushE;
    logic [1:0]        forwardAE;
    logic [1:0]        forwardBE;
    logic              mcDone;
    logic [ADDR_W-1:0] mcRd;
    logic [CNT_W-1:0]  stallCount;

    modport master (
        output rs1D, rs2D, rdD, regWriteD, rs1E, rs2E, rdE, resultSrcE, mcIssueE, PCSrcE,
               rdM, rdW, regWriteM, regWriteW,
        input  stallF, stallD, stallE, flushD, flushE, forwardAE, forwardBE, mcDone, mcRd,
               stallCount
    );

    modport slave (
        input  rs1D, rs2D, rdD, regWriteD, rs1E, rs2E, rdE, resultSrcE, mcIssueE, PCSrcE,
               rdM, rdW, regWriteM, regWriteW,
        output stallF, stallD, stallE, flushD, flushE, forwardAE, forwardBE, mcDone, mcRd,
               stallCount
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Hazard unit for the 5-stage pipeline: M/W/MC forwarding, load-use and scoreboard stalls,
// structural stalls for one non-pipelined multi-cycle unit, and a saturating stall counter.
module hazard_scoreboard #(
    parameter int REG_COUNT = 32,
    parameter int ADDR_W    = 5,
    parameter int MC_LAT    = 4,
    parameter int CNT_W     = 32
) (
    input  logic                clk,
    input  logic                rst,
    hazard_scoreboard_if.slave  hz
);
    localparam int                CW       = $clog2(MC_LAT);
    localparam logic [CW-1:0]     CNT_INIT = CW'(MC_LAT - 1);
    localparam logic [CW-1:0]     CNT_ZERO = {CW{1'b0}};
    localparam logic [ADDR_W-1:0] IDX_ZERO = {ADDR_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic {MC_IDLE = 1'b0, MC_BUSY = 1'b1} mc_state_t;

    mc_state_t              mc_state_r;
    logic [CW-1:0]          mc_cnt_r;
    logic [ADDR_W-1:0]      mc_rd_r;
    logic [REG_COUNT-1:0]   busy_r;
    logic [CNT_W-1:0]       stall_count_r;

    logic                   mc_done_s;
    logic                   struct_stall_s;
    logic                   issue_s;
    logic                   sb_stall_s;
    logic                   lu_stall_s;
    logic                   dec_stall_s;
    logic                   stall_f_s;
    logic                   flush_e_s;
    logic [1:0]             fwd_a_s;
    logic [1:0]             fwd_b_s;
    logic [REG_COUNT-1:0]   busy_next_s;

    // A register is still pending unless its MC result lands this very cycle.
    function automatic logic pending(input logic [REG_COUNT-1:0] busy, input logic [ADDR_W-1:0] r,
                                     input logic done, input logic [ADDR_W-1:0] done_rd);
        return (r != IDX_ZERO) && busy[r] && !(done && (r == done_rd));
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [ADDR_W-1:0] rs,
                                           input logic [ADDR_W-1:0] rd_m, input logic wr_m,
                                           input logic [ADDR_W-1:0] rd_w, input logic wr_w,
                                           input logic done, input logic [ADDR_W-1:0] rd_mc);
        logic [1:0] sel;
        sel = 2'b00;
        if (rs == IDX_ZERO) begin
            sel = 2'b00;
        end else if (wr_m && (rs == rd_m)) begin
            sel = 2'b10;
        end else if (wr_w && (rs == rd_w)) begin
            sel = 2'b01;
        end else if (done && (rs == rd_mc)) begin
            sel = 2'b11;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Stall, flush and forwarding decisions from the current pipeline snapshot.
    always_comb begin
        mc_done_s      = (mc_state_r == MC_BUSY) && (mc_cnt_r == CNT_ZERO);
        struct_stall_s = hz.mcIssueE && (mc_state_r == MC_BUSY) && !mc_done_s;
        issue_s        = hz.mcIssueE && !struct_stall_s;
        sb_stall_s     = pending(busy_r, hz.rs1D, mc_done_s, mc_rd_r)
                       | pending(busy_r, hz.rs2D, mc_done_s, mc_rd_r)
                       | (hz.regWriteD && pending(busy_r, hz.rdD, mc_done_s, mc_rd_r));
        lu_stall_s     = hz.resultSrcE && (hz.rdE != IDX_ZERO)
                       && ((hz.rs1D == hz.rdE) || (hz.rs2D == hz.rdE));
        // Wrong-path decode after a taken branch must not stall.
        dec_stall_s    = (sb_stall_s || lu_stall_s) && !hz.PCSrcE;
        stall_f_s      = struct_stall_s || dec_stall_s;
        // A held ID/EX (structural stall) must not also be bubbled.
        flush_e_s      = hz.PCSrcE || (dec_stall_s && !struct_stall_s);
        fwd_a_s        = fwd_sel(hz.rs1E, hz.rdM, hz.regWriteM, hz.rdW, hz.regWriteW,
                                 mc_done_s, mc_rd_r);
        fwd_b_s        = fwd_sel(hz.rs2E, hz.rdM, hz.regWriteM, hz.rdW, hz.regWriteW,
                                 mc_done_s, mc_rd_r);
    end

    // Next busy map: clear the completing destination, set a newly issued non-zero one.
    always_comb begin
        busy_next_s = {REG_COUNT{1'b0}};
        for (int i = 1; i < REG_COUNT; i++) begin
            busy_next_s[i] = (busy_r[i] && !(mc_done_s && (mc_rd_r == ADDR_W'(i))))
                           || (issue_s && (hz.rdE == ADDR_W'(i)));
        end
    end

    // MC unit FSM: issue, countdown, completion and back-to-back reissue.
    always_ff @(posedge clk) begin
        if (rst) begin
            mc_state_r <= MC_IDLE;
            mc_cnt_r   <= CNT_ZERO;
            mc_rd_r    <= IDX_ZERO;
        end else begin
            case (mc_state_r)
                MC_IDLE: begin
                    if (issue_s) begin
                        mc_state_r <= MC_BUSY;
                        mc_cnt_r   <= CNT_INIT;
                        mc_rd_r    <= hz.rdE;
                    end else begin
                        mc_state_r <= MC_IDLE;
                    end
                end
                MC_BUSY: begin
                    if (mc_done_s) begin
                        if (issue_s) begin
                            mc_cnt_r <= CNT_INIT;
                            mc_rd_r  <= hz.rdE;
                        end else begin
                            mc_state_r <= MC_IDLE;
                        end
                    end else begin
                        mc_cnt_r <= mc_cnt_r - CW'(1);
                    end
                end
                default: begin
                    mc_state_r <= MC_IDLE;
                    mc_cnt_r   <= CNT_ZERO;
                end
            endcase
        end
    end

    // Scoreboard busy bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= {REG_COUNT{1'b0}};
        end else begin
            busy_r <= busy_next_s;
        end
    end

    // Saturating count of cycles with the PC held.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count_r <= {CNT_W{1'b0}};
        end else if (stall_f_s && (stall_count_r != CNT_MAX)) begin
            stall_count_r <= stall_count_r + CNT_W'(1);
        end
    end

    assign hz.stallF     = stall_f_s;
    assign hz.stallD     = stall_f_s;
    assign hz.stallE     = struct_stall_s;
    assign hz.flushD     = hz.PCSrcE;
    assign hz.flushE     = flush_e_s;
    assign hz.forwardAE  = fwd_a_s;
    assign hz.forwardBE  = fwd_b_s;
    assign hz.mcDone     = mc_done_s;
    assign hz.mcRd       = mc_rd_r;
    assign hz.stallCount = stall_count_r;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: a vector table for single-cycle decisions,
// hand-written sequences for MC timing, reset abort and counter saturation.
module tb_hazard_scoreboard;
    logic clk;
    logic rst;

    hazard_scoreboard_if #(.ADDR_W(5), .CNT_W(32)) hz ();
    hazard_scoreboard_if #(.ADDR_W(5), .CNT_W(4))  hs ();

    hazard_scoreboard #(.REG_COUNT(32), .ADDR_W(5), .MC_LAT(4), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .hz(hz));
    hazard_scoreboard #(.REG_COUNT(32), .ADDR_W(5), .MC_LAT(4), .CNT_W(4)) dut_small (
        .clk(clk), .rst(rst), .hz(hs));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string      name;
        logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
        logic       ld, br, wm, ww;
        logic [9:0] exp;
    } vec_t;

    int          errors;
    int          checks;
    logic [31:0] exp_cnt;
    logic [9:0]  exp_q[$];
    vec_t        tbl[12];

    // {stallF, stallD, stallE, flushD, flushE, forwardAE, forwardBE, mcDone}
    function automatic logic [9:0] ctl(input logic sf, input logic se, input logic fd,
                                       input logic fe, input logic [1:0] fa,
                                       input logic [1:0] fb, input logic dn);
        return {sf, sf, se, fd, fe, fa, fb, dn};
    endfunction

    function automatic vec_t mk(input string nm, input logic [4:0] rs1D, input logic [4:0] rs2D,
                                input logic [4:0] rs1E, input logic [4:0] rs2E,
                                input logic [4:0] rdE, input logic ld, input logic br,
                                input logic [4:0] rdM, input logic wm,
                                input logic [4:0] rdW, input logic ww, input logic [9:0] e);
        vec_t v;
        v.name = nm; v.rs1D = rs1D; v.rs2D = rs2D; v.rs1E = rs1E; v.rs2E = rs2E;
        v.rdE = rdE; v.ld = ld; v.br = br; v.rdM = rdM; v.wm = wm; v.rdW = rdW;
        v.ww = ww; v.exp = e;
        return v;
    endfunction

    task automatic clr();
        hz.rs1D = 5'd0; hz.rs2D = 5'd0; hz.rdD = 5'd0; hz.regWriteD = 1'b0;
        hz.rs1E = 5'd0; hz.rs2E = 5'd0; hz.rdE = 5'd0; hz.resultSrcE = 1'b0;
        hz.mcIssueE = 1'b0; hz.PCSrcE = 1'b0; hz.rdM = 5'd0; hz.rdW = 5'd0;
        hz.regWriteM = 1'b0; hz.regWriteW = 1'b0;
    endtask

    task automatic clr_small();
        hs.rs1D = 5'd0; hs.rs2D = 5'd0; hs.rdD = 5'd0; hs.regWriteD = 1'b0;
        hs.rs1E = 5'd0; hs.rs2E = 5'd0; hs.rdE = 5'd0; hs.resultSrcE = 1'b0;
        hs.mcIssueE = 1'b0; hs.PCSrcE = 1'b0; hs.rdM = 5'd0; hs.rdW = 5'd0;
        hs.regWriteM = 1'b0; hs.regWriteW = 1'b0;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Inputs are already driven; expected control word goes through the queue and is
    // compared at the falling edge, then time advances to just after the next rising edge.
    task automatic step(input string nm, input logic [9:0] e);
        logic [9:0] act;
        logic [9:0] want;
        exp_q.push_back(e);
        @(negedge clk);
        act  = {hz.stallF, hz.stallD, hz.stallE, hz.flushD, hz.flushE,
                hz.forwardAE, hz.forwardBE, hz.mcDone};
        want = exp_q.pop_front();
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: ctl got %b expected %b", nm, act, want);
        end
        chk({nm, "_cnt"}, hz.stallCount, exp_cnt);
        if (want[9]) exp_cnt = exp_cnt + 32'd1;
        @(posedge clk);
        #1;
    endtask

    localparam logic [9:0] NONE  = 10'b0000000000;
    localparam logic [9:0] DSTL  = 10'b1100100000;  // decode stall + bubble
    localparam logic [9:0] SSTL  = 10'b1110000000;  // structural stall
    localparam logic [9:0] BRF   = 10'b0001100000;  // branch flush
    localparam logic [9:0] DONE  = 10'b0000000001;

    initial begin
        errors  = 0;
        checks  = 0;
        exp_cnt = 32'd0;
        rst     = 1'b1;
        clr();
        clr_small();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_mcDone", {31'd0, hz.mcDone}, 32'd0);
        chk("rst_mcRd", {27'd0, hz.mcRd}, 32'd0);
        chk("rst_stallCount", hz.stallCount, 32'd0);

        tbl[0]  = mk("idle",      5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, NONE);
        tbl[1]  = mk("t1_m_wins", 5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1,
                     ctl(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0));
        tbl[2]  = mk("fwd_b_w",   5'd0, 5'd0, 5'd0, 5'd6, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1,
                     ctl(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 1'b0));
        tbl[3]  = mk("fwd_a_w",   5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b0, 5'd5, 1'b1,
                     ctl(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0));
        tbl[4]  = mk("fwd_x0",    5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, NONE);
        tbl[5]  = mk("fwd_both",  5'd0, 5'd0, 5'd4, 5'd4, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1, 5'd0, 1'b0,
                     ctl(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b10, 1'b0));
        tbl[6]  = mk("t2_ld_use", 5'd0, 5'd3, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, DSTL);
        tbl[7]  = mk("t2_ld_x0",  5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, NONE);
        tbl[8]  = mk("ld_nomatch",5'd4, 5'd5, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, NONE);
        tbl[9]  = mk("t5_br_ld",  5'd3, 5'd0, 5'd0, 5'd0, 5'd3, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, BRF);
        tbl[10] = mk("branch",    5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, BRF);
        tbl[11] = mk("not_load",  5'd3, 5'd0, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, NONE);

        for (int i = 0; i < 12; i++) begin
            clr();
            hz.rs1D = tbl[i].rs1D; hz.rs2D = tbl[i].rs2D; hz.rs1E = tbl[i].rs1E;
            hz.rs2E = tbl[i].rs2E; hz.rdE = tbl[i].rdE; hz.resultSrcE = tbl[i].ld;
            hz.PCSrcE = tbl[i].br; hz.rdM = tbl[i].rdM; hz.regWriteM = tbl[i].wm;
            hz.rdW = tbl[i].rdW; hz.regWriteW = tbl[i].ww;
            step(tbl[i].name, tbl[i].exp);
        end

        // T3: MC op to x7, RAW/WAW scoreboard stalls, release and MC forward on completion
        clr(); hz.mcIssueE = 1'b1; hz.rdE = 5'd7;
        step("t3_issue", NONE);
        clr(); hz.rs1D = 5'd7; hz.rs1E = 5'd7;
        step("t3_raw_c1", DSTL);
        clr(); hz.rdD = 5'd7; hz.regWriteD = 1'b1; hz.rs1E = 5'd7;
        step("t3_waw_c2", DSTL);
        clr(); hz.rs1D = 5'd7; hz.rdD = 5'd7; hz.rs1E = 5'd7;
        step("t3_raw_c3", DSTL);
        clr(); hz.rs1D = 5'd7; hz.rs1E = 5'd7;
        step("t3_done_c4", ctl(1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 1'b1));
        chk("t3_mcRd", {27'd0, hz.mcRd}, 32'd7);
        clr(); hz.rs1D = 5'd7; hz.rdD = 5'd7; hz.regWriteD = 1'b1; hz.rs1E = 5'd7;
        step("t3_cleared", NONE);

        // T4: second issue while busy is held until the completion cycle
        clr(); hz.mcIssueE = 1'b1; hz.rdE = 5'd9;
        step("t4_issue", NONE);
        clr();
        step("t4_c1", NONE);
        for (int c = 2; c < 4; c++) begin
            clr(); hz.mcIssueE = 1'b1; hz.rdE = 5'd10;
            step("t4_struct", SSTL);
        end
        clr(); hz.mcIssueE = 1'b1; hz.rdE = 5'd10;
        step("t4_accept", DONE);
        for (int c = 5; c < 8; c++) begin
            clr(); hz.rs1D = 5'd10; hz.rs2D = 5'd9;
            step("t4_raw10", DSTL);
        end
        clr(); hz.rs1D = 5'd10; hz.rs2D = 5'd9;
        step("t4_done10", DONE);
        chk("t4_mcRd", {27'd0, hz.mcRd}, 32'd10);

        // MC op targeting x0 occupies the unit but never forwards or marks busy
        clr(); hz.mcIssueE = 1'b1; hz.rdE = 5'd0;
        step("x0_issue", NONE);
        for (int c = 1; c < 4; c++) begin
            clr(); hz.mcIssueE = 1'b1; hz.rdE = 5'd11; hz.rs1D = 5'd0;
            step("x0_struct", SSTL);
        end
        clr(); hz.mcIssueE = 1'b1; hz.rdE = 5'd11;
        step("x0_done_nofwd", DONE);
        for (int c = 5; c < 8; c++) begin
            clr(); hz.rs1D = 5'd11;
            step("x0_raw11", DSTL);
        end
        clr(); hz.rs1D = 5'd11; hz.rs2E = 5'd11;
        step("x0_fwd_b_mc", ctl(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b11, 1'b1));

        // T6: reset while busy with one cycle left aborts without a completion pulse
        clr(); hz.mcIssueE = 1'b1; hz.rdE = 5'd12;
        step("t6_issue", NONE);
        clr(); hz.rs1D = 5'd12;
        step("t6_c1", DSTL);
        step("t6_c2", DSTL);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_nodone", {31'd0, hz.mcDone}, 32'd0);
        chk("t6_rst_stall", {31'd0, hz.stallF}, 32'd1);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        exp_cnt = 32'd0;
        step("t6_busy_clr", NONE);
        clr();
        step("t6_no_late_done", NONE);
        step("t6_idle", NONE);

        // Counter saturation on a 4-bit instance via a sustained load-use stall
        hs.resultSrcE = 1'b1; hs.rdE = 5'd3; hs.rs1D = 5'd3;
        repeat (14) @(posedge clk);
        #1;
        chk("sat_14", {28'd0, hs.stallCount}, 32'd14);
        repeat (6) @(posedge clk);
        #1;
        chk("sat_20", {28'd0, hs.stallCount}, 32'd15);
        clr_small();
        @(posedge clk);
        #1;
        chk("sat_hold", {28'd0, hs.stallCount}, 32'd15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
